// File: rtl/uart_line_writer_pkg.sv
// Shared types and defaults for the UART line writer.
// State encoding, answer codes and a saturating counter helper.
package uart2vga_pkg;

  typedef enum logic [2:0] {
    S_ROW,
    S_PAY,
    S_CSUM,
    S_END,
    S_COMMIT,
    S_ANS
  } line_state_t;

  localparam logic [7:0] DEF_END_CODE = 8'hFF;
  localparam logic [7:0] DEF_ANS_OK   = 8'hAA;
  localparam logic [7:0] DEF_ANS_ERR  = 8'h55;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_line_writer_buf.sv
// Line payload store: byte-wide write port, pixel-wide read port.
// Pixel x sits at payload bits [x*BPP +: BPP], LSB-first across bytes.
module line_pack_buf #(
  parameter int PAY_BYTES = 240,
  parameter int BPP       = 3,
  parameter int AW        = 8,
  parameter int XW        = 10
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [AW-1:0]  waddr_i,
  input  logic [7:0]     wdata_i,
  input  logic [XW-1:0]  x_i,
  output logic [BPP-1:0] pix_o
);

  localparam int BAW = $clog2(PAY_BYTES);
  localparam int FW  = PAY_BYTES * 8;
  localparam int IW  = $clog2(FW);

  logic [7:0]    mem_q [PAY_BYTES];
  logic [FW-1:0] flat;
  logic [IW-1:0] idx;

  // Byte store, written while the payload streams in
  always_ff @(posedge clk) begin
    if (we_i) mem_q[BAW'(waddr_i)] <= wdata_i;
  end

  // Flatten bytes into one bit vector for pixel extraction
  always_comb begin
    flat = '0;
    for (int i = 0; i < PAY_BYTES; i++)
      flat[i*8 +: 8] = mem_q[i];
  end

  assign idx   = IW'(x_i) * IW'(BPP);
  assign pix_o = flat[idx +: BPP];

endmodule

// File: rtl/uart_line_writer.sv
// Parses framed line packets from the UART and commits valid
// lines to the framebuffer, answering each packet with OK/ERR.
module uart_line_writer
  import uart2vga_pkg::*;
#(
  parameter int         WIDTH    = 640,
  parameter int         HEIGHT   = 480,
  parameter int         BPP      = 3,
  parameter logic [7:0] END_CODE = DEF_END_CODE,
  parameter logic [7:0] ANS_OK   = DEF_ANS_OK,
  parameter logic [7:0] ANS_ERR  = DEF_ANS_ERR,
  parameter int         TIMEOUT  = 1000000,
  localparam int ROW_W     = $clog2(HEIGHT),
  localparam int ADDR_W    = $clog2(WIDTH * HEIGHT),
  localparam int ROW_BYTES = (ROW_W + 7) / 8,
  localparam int PAY_BYTES = (WIDTH * BPP + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [BPP-1:0]    fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              busy,
  output logic              line_done,
  output logic [15:0]       err_cnt
);

  localparam int RBW   = ROW_BYTES * 8;
  localparam int XW    = $clog2(WIDTH);
  localparam int CNT_W = $clog2(PAY_BYTES + ROW_BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1) + 1;

  line_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RBW-1:0]    row_q, row_d;
  logic [7:0]        csum_q, csum_d;
  logic              bad_q, bad_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [XW-1:0]     x_q, x_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              ok_q, ok_d;
  logic [15:0]       err_q, err_d;
  logic              done_q, done_d;
  logic              acc, run, err_ev, wr_en;
  logic [BPP-1:0]    pix;

  line_pack_buf #(
    .PAY_BYTES(PAY_BYTES),
    .BPP      (BPP),
    .AW       (CNT_W),
    .XW       (XW)
  ) u_buf (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(cnt_q),
    .wdata_i(rx_data),
    .x_i    (x_q),
    .pix_o  (pix)
  );

  assign acc = rx_valid & (state_q inside {S_ROW, S_PAY, S_CSUM, S_END});

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ROW;
      cnt_q   <= '0;
      row_q   <= '0;
      csum_q  <= '0;
      bad_q   <= 1'b0;
      tmo_q   <= '0;
      x_q     <= '0;
      base_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      csum_q  <= csum_d;
      bad_q   <= bad_d;
      tmo_q   <= tmo_d;
      x_q     <= x_d;
      base_q  <= base_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Packet parsing, commit sequencing and idle timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    csum_d  = csum_q;
    bad_d   = bad_q;
    tmo_d   = tmo_q;
    x_d     = x_q;
    base_d  = base_q;
    ok_d    = ok_q;
    err_d   = err_q;
    done_d  = 1'b0;
    err_ev  = 1'b0;
    wr_en   = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      S_ROW: begin
        run = (cnt_q != '0);
        if (rx_valid) begin
          row_d = RBW'({row_q, rx_data});
          if (cnt_q == CNT_W'(ROW_BYTES - 1)) begin
            state_d = S_PAY;
            cnt_d   = '0;
            csum_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PAY: begin
        run = 1'b1;
        if (rx_valid) begin
          wr_en  = 1'b1;
          csum_d = csum_q ^ rx_data;
          if (cnt_q == CNT_W'(PAY_BYTES - 1)) begin
            state_d = S_CSUM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CSUM: begin
        run = 1'b1;
        if (rx_valid) begin
          bad_d   = (rx_data != csum_q);
          state_d = S_END;
        end
      end
      S_END: begin
        run = 1'b1;
        if (rx_valid) begin
          if (rx_data != END_CODE || 32'(row_q) >= HEIGHT || bad_q) begin
            state_d = S_ANS;
            ok_d    = 1'b0;
            err_ev  = 1'b1;
          end else begin
            state_d = S_COMMIT;
            x_d     = '0;
            base_d  = ADDR_W'(row_q) * ADDR_W'(WIDTH);
          end
        end
      end
      S_COMMIT: begin
        if (fb_ready) begin
          if (x_q == XW'(WIDTH - 1)) begin
            state_d = S_ANS;
            ok_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_ANS: begin
        if (tx_ready) begin
          state_d = S_ROW;
          cnt_d   = '0;
        end
      end
      default: state_d = S_ROW;
    endcase
    if (acc) begin
      tmo_d = '0;
    end else if (TIMEOUT != 0 && run) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        state_d = S_ANS;
        ok_d    = 1'b0;
        err_ev  = 1'b1;
        tmo_d   = '0;
        cnt_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (err_ev) err_d = sat_inc16(err_q);
  end

  // Output decode from the current state
  always_comb begin
    fb_we     = (state_q == S_COMMIT);
    fb_addr   = '0;
    fb_data   = '0;
    tx_valid  = (state_q == S_ANS);
    tx_data   = '0;
    if (fb_we) begin
      fb_addr = base_q + ADDR_W'(x_q);
      fb_data = pix;
    end
    if (tx_valid) tx_data = ok_q ? ANS_OK : ANS_ERR;
    busy      = (state_q != S_ROW) || (cnt_q != '0);
    line_done = done_q;
    err_cnt   = err_q;
  end

endmodule

// File: tb/tb_uart_line_writer.sv
// Randomized self-checking bench for uart_line_writer.
// Packets are built from pixel arrays; expectations from packet rules.
module tb_uart_line_writer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int B  = 3;
  localparam int TO = 64;
  localparam int PB = (W * B + 7) / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [4:0] fb_addr;
  logic [2:0] fb_data;
  logic       fb_we;
  logic       fb_ready = 1'b1;
  logic       busy;
  logic       line_done;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  uart_line_writer #(
    .WIDTH(W), .HEIGHT(H), .BPP(B), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .fb_ready(fb_ready),
    .busy(busy), .line_done(line_done), .err_cnt(err_cnt)
  );

  int vec = 0;
  int bad = 0;
  int model_err = 0;
  int cyc = 0;
  int ready_mode = 0;

  logic [2:0] px [W];
  logic [7:0] pkt [$];
  int wr_addr [$];
  int wr_data [$];
  logic [7:0] txq [$];
  int done_n, we_seen, stall_bad, first_wr, ans_cyc;
  logic prev_stall = 1'b0;
  logic [4:0] prev_addr;
  logic [2:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: fb_ready = 1'b1;
      1: fb_ready = ~fb_ready;
      default: fb_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (fb_we) we_seen++;
    if (fb_we && fb_ready) begin
      if (wr_addr.size() == 0) first_wr = cyc;
      wr_addr.push_back(int'(fb_addr));
      wr_data.push_back(int'(fb_data));
    end
    if (prev_stall && fb_we &&
        (fb_addr !== prev_addr || fb_data !== prev_data))
      stall_bad++;
    prev_stall = fb_we && !fb_ready;
    prev_addr  = fb_addr;
    prev_data  = fb_data;
    if (tx_valid && tx_ready) begin
      txq.push_back(tx_data);
      ans_cyc = cyc;
    end
    if (line_done) done_n++;
  end

  task automatic clear_mon();
    txq.delete();
    wr_addr.delete();
    wr_data.delete();
    done_n = 0;
    we_seen = 0;
    stall_bad = 0;
    first_wr = -1;
    ans_cyc = -1;
  endtask

  task automatic build(input int row, input bit cs_force,
                       input logic [7:0] cs_val, input logic [7:0] endb);
    logic [PB*8-1:0] bits;
    logic [7:0] cs, b;
    bits = '0;
    for (int x = 0; x < W; x++) bits[x*B +: B] = px[x];
    pkt.delete();
    pkt.push_back(8'(row));
    cs = '0;
    for (int i = 0; i < PB; i++) begin
      b = bits[i*8 +: 8];
      pkt.push_back(b);
      cs ^= b;
    end
    pkt.push_back(cs_force ? cs_val : cs);
    pkt.push_back(endb);
  endtask

  task automatic send_pkt(input int gap_max, output int acc_cyc);
    foreach (pkt[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
      rx_data = pkt[i];
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    acc_cyc = cyc;
  endtask

  task automatic wait_ans(input string nm);
    int n = 0;
    while (txq.size() == 0 && n < 400) begin
      @(posedge clk); n++;
    end
    #1;
    if (txq.size() == 0) begin
      bad++;
      $display("FAIL %s_answer_timeout: no answer within %0d cycles, need 1", nm, n);
    end
  endtask

  task automatic check_pkt(input string nm, input int row, input bit exp_ok);
    logic [7:0] exp_tx;
    exp_tx = exp_ok ? 8'hAA : 8'h55;
    vec++;
    if (txq.size() != 1 || txq[0] !== exp_tx) begin
      bad++;
      $display("FAIL %s_tx: got %0d answers first=%h, need 1 answer %h",
               nm, txq.size(), (txq.size() > 0) ? txq[0] : 8'h00, exp_tx);
    end
    if (exp_ok) begin
      vec++;
      if (wr_addr.size() != W) begin
        bad++;
        $display("FAIL %s_wr_count: got %0d, need %0d", nm, wr_addr.size(), W);
      end else begin
        for (int x = 0; x < W; x++) begin
          vec++;
          if (wr_addr[x] != row * W + x || wr_data[x] != int'(px[x])) begin
            bad++;
            $display("FAIL %s_wr%0d: got addr %0d data %0d, need addr %0d data %0d",
                     nm, x, wr_addr[x], wr_data[x], row * W + x, px[x]);
          end
        end
      end
      vec++;
      if (done_n != 1) begin
        bad++;
        $display("FAIL %s_line_done: got %0d pulses, need 1", nm, done_n);
      end
    end else begin
      model_err++;
      vec++;
      if (we_seen != 0 || done_n != 0) begin
        bad++;
        $display("FAIL %s_no_write: got %0d we cycles %0d done, need 0 0",
                 nm, we_seen, done_n);
      end
    end
    vec++;
    if (err_cnt !== 16'(model_err)) begin
      bad++;
      $display("FAIL %s_err_cnt: got %0d, need %0d", nm, err_cnt, model_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({tx_valid, tx_data, fb_we, fb_addr, fb_data, line_done, busy} !== '0
        || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset: got txv=%b txd=%h we=%b a=%0d d=%0d ld=%b busy=%b err=%0d, need all 0",
               tx_valid, tx_data, fb_we, fb_addr, fb_data, line_done, busy, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_good();
    int a;
    for (int x = 0; x < W; x++) px[x] = 3'(x);
    ready_mode = 0;
    clear_mon();
    build(2, 1'b0, 8'h00, 8'hFF);
    send_pkt(0, a);
    wait_ans("good");
    check_pkt("good", 2, 1'b1);
    vec++;
    if (first_wr != a || ans_cyc != a + W) begin
      bad++;
      $display("FAIL good_latency: got first_wr %0d ans %0d, need %0d %0d",
               first_wr, ans_cyc, a, a + W);
    end
  endtask

  task automatic test_bad_csum();
    int a;
    clear_mon();
    build(2, 1'b1, 8'h00, 8'hFF);
    send_pkt(1, a);
    wait_ans("bad_csum");
    check_pkt("bad_csum", 2, 1'b0);
  endtask

  task automatic test_bad_row();
    int a;
    clear_mon();
    build(5, 1'b0, 8'h00, 8'hFF);
    send_pkt(1, a);
    wait_ans("bad_row");
    check_pkt("bad_row", 5, 1'b0);
  endtask

  task automatic test_stall();
    int a;
    for (int x = 0; x < W; x++) px[x] = 3'($urandom);
    ready_mode = 1;
    clear_mon();
    build(1, 1'b0, 8'h00, 8'hFF);
    send_pkt(0, a);
    wait_ans("stall");
    check_pkt("stall", 1, 1'b1);
    vec++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL stall_hold: got %0d changes while stalled, need 0", stall_bad);
    end
    ready_mode = 0;
  endtask

  task automatic test_timeout();
    int a;
    clear_mon();
    pkt.delete();
    pkt.push_back(8'h02);
    pkt.push_back(8'h88);
    send_pkt(0, a);
    wait_ans("timeout");
    check_pkt("timeout", 2, 1'b0);
    vec++;
    if (ans_cyc < a + TO - 1 || ans_cyc > a + TO + 1) begin
      bad++;
      $display("FAIL timeout_time: got answer at +%0d, need +%0d", ans_cyc - a, TO);
    end
    @(negedge clk);
    vec++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: got busy %b, need 0", busy);
    end
    @(posedge clk); #1;
    test_good();
  endtask

  task automatic test_reset_commit();
    int a, n;
    for (int x = 0; x < W; x++) px[x] = 3'($urandom);
    ready_mode = 0;
    clear_mon();
    build(3, 1'b0, 8'h00, 8'hFF);
    foreach (pkt[i]) begin
      rx_data = pkt[i];
      rx_valid = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    n = 0;
    while (!(fb_we && fb_addr == 5'(3 * W + 3)) && n < 50) begin
      @(negedge clk); n++;
    end
    rst = 1'b1;
    @(negedge clk);
    model_err = 0;
    vec++;
    if (fb_we !== 1'b0 || tx_valid !== 1'b0 || err_cnt !== 16'd0 || n >= 50) begin
      bad++;
      $display("FAIL reset_commit: got we=%b txv=%b err=%0d wait=%0d, need 0 0 0 <50",
               fb_we, tx_valid, err_cnt, n);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_drop_in_ans();
    int a, n;
    clear_mon();
    tx_ready = 1'b0;
    build(1, 1'b1, 8'h00, 8'hFF);
    send_pkt(0, a);
    n = 0;
    while (!tx_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    build(0, 1'b0, 8'h00, 8'hFF);
    send_pkt(0, a);
    tx_ready = 1'b1;
    wait_ans("drop");
    check_pkt("drop", 1, 1'b0);
    @(negedge clk);
    vec++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: got busy %b, need 0", busy);
    end
    @(posedge clk); #1;
    clear_mon();
    send_pkt(0, a);
    wait_ans("after_drop");
    check_pkt("after_drop", 0, 1'b1);
  endtask

  task automatic test_random();
    int a, row;
    bit csb, endb, ok;
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      row  = $urandom_range(0, 5);
      csb  = ($urandom_range(0, 3) == 0);
      endb = ($urandom_range(0, 5) == 0);
      for (int x = 0; x < W; x++) px[x] = 3'($urandom);
      clear_mon();
      tx_ready = 1'b0;
      build(row, 1'b0, 8'h00, endb ? 8'hFE : 8'hFF);
      if (csb) pkt[PB + 1] = pkt[PB + 1] ^ 8'h10;
      send_pkt(2, a);
      repeat ($urandom_range(0, 5)) begin
        @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      ok = (row < H) && !csb && !endb;
      wait_ans("random");
      check_pkt("random", row, ok);
      vec++;
      if (stall_bad != 0) begin
        bad++;
        $display("FAIL random_stall: got %0d changes while stalled, need 0", stall_bad);
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_bad_row();
    test_stall();
    test_timeout();
    test_reset_commit();
    test_drop_in_ans();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
